// File: rtl/decode_stage.sv
// RV32I decode pipeline register: latency 1, valid/ready handshake, holds all outputs while out_ready=0.
// Load-use hazards insert LOAD_LAT bubbles; define HALT_DETECT_EN to decode opcode 7'h7F as HALT (adds out_halt).
package cpu_types_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } aluop_t;
endpackage

module decode_stage
   import cpu_types_pkg::*;
#(
   parameter int WORD_W   = 32,
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_instr,
   input  logic [WORD_W-1:0] in_pc,
   output logic              in_ready,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_pc,
   output logic [REG_W-1:0]  out_rs1,
   output logic [REG_W-1:0]  out_rs2,
   output logic [REG_W-1:0]  out_rd,
   output logic [WORD_W-1:0] out_imm,
   output aluop_t            out_aluOp,
   output logic              out_aluSrc,
   output logic              out_shift,
   output logic              out_regWr,
   output logic              out_dREN,
   output logic              out_dWEN,
   output logic [2:0]        out_rdSel,
   output logic [1:0]        out_pcSrc,
   output logic [2:0]        out_brType,
   output logic              out_illegal
`ifdef HALT_DETECT_EN
   ,
   output logic              out_halt
`endif
);

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
`ifdef HALT_DETECT_EN
   localparam logic [6:0] OP_HALT   = 7'h7F;
`endif

   typedef enum logic {RUN, STALL} state_t;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic [REG_W-1:0]  rd;
      logic [WORD_W-1:0] imm;
      aluop_t            aluop;
      logic              alusrc;
      logic              shift;
      logic              regwr;
      logic              dren;
      logic              dwen;
      logic [2:0]        rdsel;
      logic [1:0]        pcsrc;
      logic [2:0]        brtype;
      logic              ill;
`ifdef HALT_DETECT_EN
      logic              halt;
`endif
   } dec_t;

   function automatic aluop_t alu_sel(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    alu_sel = alt ? ALU_SUB : ALU_ADD;
         3'd1:    alu_sel = ALU_SLL;
         3'd2:    alu_sel = ALU_SLT;
         3'd3:    alu_sel = ALU_SLTU;
         3'd4:    alu_sel = ALU_XOR;
         3'd5:    alu_sel = alt ? ALU_SRA : ALU_SRL;
         3'd6:    alu_sel = ALU_OR;
         default: alu_sel = ALU_AND;
      endcase
   endfunction

   logic [31:0] ins;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        alt;
   logic [31:0] imm32;
   logic        use_rs1, use_rs2, use_rd;
   logic        hazard, advance, take, halt_blk;
   dec_t        d, q;
   logic        vld_q;
   state_t      state_q;
   logic [2:0]  cnt_q;

   assign ins = in_instr[31:0];
   assign opc = ins[6:0];
   assign f3  = ins[14:12];
   assign f7  = ins[31:25];
   assign alt = (f7 == 7'b0100000);

   always_comb begin
      d       = '0;
      d.pc    = in_pc;
      imm32   = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      case (opc)
         OP_R: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            d.regwr = 1'b1;
            d.aluop = alu_sel(f3, alt);
            d.shift = (f3 == 3'd1) || (f3 == 3'd5);
            d.ill   = !((f7 == 7'd0) || (alt && ((f3 == 3'd0) || (f3 == 3'd5))));
         end
         OP_IMM: begin
            use_rs1  = 1'b1; use_rd = 1'b1;
            imm32    = {{20{ins[31]}}, ins[31:20]};
            d.regwr  = 1'b1;
            d.alusrc = 1'b1;
            // imm[11:5] only selects SRA for the right shift; for other ops it is immediate data
            d.aluop  = alu_sel(f3, (f3 == 3'd5) && alt);
            d.shift  = (f3 == 3'd1) || (f3 == 3'd5);
            if (f3 == 3'd1)      d.ill = (f7 != 7'd0);
            else if (f3 == 3'd5) d.ill = !((f7 == 7'd0) || alt);
         end
         OP_LOAD: begin
            use_rs1  = 1'b1; use_rd = 1'b1;
            imm32    = {{20{ins[31]}}, ins[31:20]};
            d.regwr  = 1'b1;
            d.alusrc = 1'b1;
            d.dren   = 1'b1;
            d.rdsel  = 3'd1;
            d.ill    = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         end
         OP_STORE: begin
            use_rs1  = 1'b1; use_rs2 = 1'b1;
            imm32    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            d.alusrc = 1'b1;
            d.dwen   = 1'b1;
            d.ill    = (f3 > 3'd2);
         end
         OP_BRANCH: begin
            use_rs1  = 1'b1; use_rs2 = 1'b1;
            imm32    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            d.aluop  = ALU_SUB;
            d.pcsrc  = 2'd1;
            d.brtype = f3;
            d.ill    = (f3 == 3'd2) || (f3 == 3'd3);
         end
         OP_JAL: begin
            use_rd  = 1'b1;
            imm32   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            d.regwr = 1'b1;
            d.rdsel = 3'd2;
            d.pcsrc = 2'd3;
         end
         OP_JALR: begin
            use_rs1  = 1'b1; use_rd = 1'b1;
            imm32    = {{20{ins[31]}}, ins[31:20]};
            d.regwr  = 1'b1;
            d.alusrc = 1'b1;
            d.rdsel  = 3'd2;
            d.pcsrc  = 2'd2;
            d.ill    = (f3 != 3'd0);
         end
         OP_LUI: begin
            use_rd   = 1'b1;
            imm32    = {ins[31:12], 12'd0};
            d.regwr  = 1'b1;
            d.alusrc = 1'b1;
            d.rdsel  = 3'd3;
         end
         OP_AUIPC: begin
            use_rd   = 1'b1;
            imm32    = {ins[31:12], 12'd0};
            d.regwr  = 1'b1;
            d.alusrc = 1'b1;
            d.rdsel  = 3'd4;
         end
`ifdef HALT_DETECT_EN
         OP_HALT: d.halt = 1'b1;
`endif
         default: d.ill = 1'b1;
      endcase

      // unused register fields are zeroed so they never match a pending load
      d.rs1 = use_rs1 ? REG_W'(ins[19:15]) : '0;
      d.rs2 = use_rs2 ? REG_W'(ins[24:20]) : '0;
      d.rd  = use_rd  ? REG_W'(ins[11:7])  : '0;
      d.imm = WORD_W'($signed(imm32));

      if (d.ill) begin
         d.aluop  = ALU_ADD;
         d.alusrc = 1'b0;
         d.shift  = 1'b0;
         d.regwr  = 1'b0;
         d.dren   = 1'b0;
         d.dwen   = 1'b0;
         d.rdsel  = 3'd0;
         d.pcsrc  = 2'd0;
         d.brtype = 3'd0;
      end
      if (d.rd == '0) d.regwr = 1'b0;
   end

   assign advance = !vld_q || out_ready;
   assign hazard  = vld_q && q.dren && (q.rd != '0) &&
                    ((d.rs1 == q.rd) || (d.rs2 == q.rd));

`ifdef HALT_DETECT_EN
   logic halted_q;
   assign halt_blk = halted_q;

   // only reset releases a halted stage
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)               halted_q <= 1'b0;
      else if (take && d.halt) halted_q <= 1'b1;
   end
`else
   assign halt_blk = 1'b0;
`endif

   assign in_ready = nRST && advance && (state_q == RUN) && !hazard && !flush && !halt_blk;
   assign take     = in_valid && in_ready;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         q       <= '0;
         vld_q   <= 1'b0;
         state_q <= RUN;
         cnt_q   <= 3'd0;
      end else if (flush) begin
         q       <= '0;
         vld_q   <= 1'b0;
         state_q <= RUN;
         cnt_q   <= 3'd0;
      end else if (state_q == STALL) begin
         cnt_q <= cnt_q - 3'd1;
         if (cnt_q == 3'd1) state_q <= RUN;
      end else if (advance) begin
         if (take) begin
            q     <= d;
            vld_q <= 1'b1;
         end else begin
            q     <= '0;
            vld_q <= 1'b0;
            if (in_valid && hazard) begin
               cnt_q <= 3'(LOAD_LAT - 1);
               if (LOAD_LAT > 1) state_q <= STALL;
            end
         end
      end
   end

   assign out_valid   = vld_q;
   assign out_pc      = q.pc;
   assign out_rs1     = q.rs1;
   assign out_rs2     = q.rs2;
   assign out_rd      = q.rd;
   assign out_imm     = q.imm;
   assign out_aluOp   = q.aluop;
   assign out_aluSrc  = q.alusrc;
   assign out_shift   = q.shift;
   assign out_regWr   = q.regwr;
   assign out_dREN    = q.dren;
   assign out_dWEN    = q.dwen;
   assign out_rdSel   = q.rdsel;
   assign out_pcSrc   = q.pcsrc;
   assign out_brType  = q.brtype;
   assign out_illegal = q.ill;
`ifdef HALT_DETECT_EN
   assign out_halt    = q.halt;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (LOAD_LAT=2); HALT_DETECT_EN selects the HALT vectors.
module tb_decode_stage;
   import cpu_types_pkg::*;

   localparam int LOAD_LAT = 2;

   logic        CLK = 1'b0;
   logic        nRST, flush, in_valid, in_ready, out_ready, out_valid;
   logic [31:0] in_instr, in_pc, out_pc, out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   aluop_t      out_aluOp;
   logic        out_aluSrc, out_shift, out_regWr, out_dREN, out_dWEN, out_illegal;
   logic [2:0]  out_rdSel, out_brType;
   logic [1:0]  out_pcSrc;
`ifdef HALT_DETECT_EN
   logic        out_halt;
`endif

   decode_stage #(.WORD_W(32), .REG_W(5), .LOAD_LAT(LOAD_LAT)) dut (
      .CLK(CLK), .nRST(nRST), .flush(flush),
      .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
      .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
      .out_aluOp(out_aluOp), .out_aluSrc(out_aluSrc), .out_shift(out_shift),
      .out_regWr(out_regWr), .out_dREN(out_dREN), .out_dWEN(out_dWEN),
      .out_rdSel(out_rdSel), .out_pcSrc(out_pcSrc), .out_brType(out_brType),
      .out_illegal(out_illegal)
`ifdef HALT_DETECT_EN
      , .out_halt(out_halt)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic [3:0]  aluop;
      logic        alusrc, shift, regwr, dren, dwen;
      logic [2:0]  rdsel;
      logic [1:0]  pcsrc;
      logic [2:0]  brtype;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                               input logic [31:0] imm, input aluop_t op,
                               input logic src, sh, wr, ren, wen,
                               input logic [2:0] rdsel, input logic [1:0] pcsrc,
                               input logic [2:0] br, input logic ill);
      exp_t e;
      e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.aluop = op;
      e.alusrc = src; e.shift = sh; e.regwr = wr; e.dren = ren; e.dwen = wen;
      e.rdsel = rdsel; e.pcsrc = pcsrc; e.brtype = br; e.ill = ill;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // monitor: one comparison per transfer to execute
   always @(negedge CLK) begin
      if (nRST && out_valid && out_ready) begin
         exp_t a, e;
         a.pc = out_pc; a.rs1 = out_rs1; a.rs2 = out_rs2; a.rd = out_rd; a.imm = out_imm;
         a.aluop = out_aluOp; a.alusrc = out_aluSrc; a.shift = out_shift; a.regwr = out_regWr;
         a.dren = out_dREN; a.dwen = out_dWEN; a.rdsel = out_rdSel; a.pcsrc = out_pcSrc;
         a.brtype = out_brType; a.ill = out_illegal;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output pc=%h: got %h, expected nothing", out_pc, a);
         end else begin
            e = sb.pop_front();
            if (a !== e) begin
               miscompares++;
               $display("FAIL decode pc=%h: got %h, expected %h", e.pc, a, e);
            end
         end
      end
   end

   task automatic send(input logic [31:0] instr, input exp_t e);
      int n = 0;
      in_valid = 1'b1; in_instr = instr; in_pc = e.pc;
      do begin
         @(negedge CLK);
         n++;
      end while (!in_ready && n < 20);
      if (!in_ready) begin
         vectors++; miscompares++;
         $display("FAIL accept_timeout pc=%h: got in_ready=0, expected 1", e.pc);
      end else begin
         sb.push_back(e);
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge CLK);
         n++;
      end
      chk("drain_empty", sb.size(), 0);
      sb.delete();
      @(posedge CLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      nRST = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h0;
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_imm", out_imm, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_regWr", out_regWr, 0);
      in_valid = 1'b0;
      @(negedge CLK); nRST = 1'b1;
      @(posedge CLK); #1;
      chk("run_in_ready", in_ready, 1);

      send(32'h002081B3, mk(32'h100, 1, 2, 3, 32'h0,        ALU_ADD, 0,0,1,0,0, 3'd0, 2'd0, 3'd0, 0));
      send(32'hFE20AE23, mk(32'h104, 1, 2, 0, 32'hFFFFFFFC, ALU_ADD, 1,0,0,0,1, 3'd0, 2'd0, 3'd0, 0));
      send(32'h4031D213, mk(32'h108, 3, 0, 4, 32'h403,      ALU_SRA, 1,1,1,0,0, 3'd0, 2'd0, 3'd0, 0));
      send(32'h0020C863, mk(32'h10C, 1, 2, 0, 32'h10,       ALU_SUB, 0,0,0,0,0, 3'd0, 2'd1, 3'd4, 0));
      send(32'h001000EF, mk(32'h110, 0, 0, 1, 32'h800,      ALU_ADD, 0,0,1,0,0, 3'd2, 2'd3, 3'd0, 0));
      send(32'hFFDFF06F, mk(32'h114, 0, 0, 0, 32'hFFFFFFFC, ALU_ADD, 0,0,0,0,0, 3'd2, 2'd3, 3'd0, 0));
      send(32'h12345537, mk(32'h118, 0, 0,10, 32'h12345000, ALU_ADD, 1,0,1,0,0, 3'd3, 2'd0, 3'd0, 0));
      send(32'h00C280E7, mk(32'h11C, 5, 0, 1, 32'hC,        ALU_ADD, 1,0,1,0,0, 3'd2, 2'd2, 3'd0, 0));
      send(32'hFFFFF117, mk(32'h120, 0, 0, 2, 32'hFFFFF000, ALU_ADD, 1,0,1,0,0, 3'd4, 2'd0, 3'd0, 0));
      send(32'h00000000, mk(32'h124, 0, 0, 0, 32'h0,        ALU_ADD, 0,0,0,0,0, 3'd0, 2'd0, 3'd0, 1));
      send(32'h022081B3, mk(32'h128, 1, 2, 3, 32'h0,        ALU_ADD, 0,0,0,0,0, 3'd0, 2'd0, 3'd0, 1));
`ifndef HALT_DETECT_EN
      send(32'h0000007F, mk(32'h12C, 0, 0, 0, 32'h0,        ALU_ADD, 0,0,0,0,0, 3'd0, 2'd0, 3'd0, 1));
`endif
      drain();

      // load-use: lw x5 then add x6,x5,x1 -> two empty cycles
      send(32'h00812283, mk(32'h200, 2, 0, 5, 32'h8, ALU_ADD, 1,0,1,1,0, 3'd1, 2'd0, 3'd0, 0));
      in_valid = 1'b1; in_instr = 32'h00128333; in_pc = 32'h204;
      @(negedge CLK); chk("lu_c0_in_ready", in_ready, 0); chk("lu_c0_out_valid", out_valid, 1);
      @(negedge CLK); chk("lu_c1_in_ready", in_ready, 0); chk("lu_c1_out_valid", out_valid, 0);
      @(negedge CLK); chk("lu_c2_in_ready", in_ready, 1); chk("lu_c2_out_valid", out_valid, 0);
      sb.push_back(mk(32'h204, 5, 1, 6, 32'h0, ALU_ADD, 0,0,1,0,0, 3'd0, 2'd0, 3'd0, 0));
      @(posedge CLK); #1; in_valid = 1'b0;
      drain();

      // backpressure: held add must stay put for three cycles
      out_ready = 1'b0;
      send(32'h002081B3, mk(32'h300, 1, 2, 3, 32'h0, ALU_ADD, 0,0,1,0,0, 3'd0, 2'd0, 3'd0, 0));
      in_valid = 1'b1; in_instr = 32'h12345537; in_pc = 32'h304;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_pc", out_pc, 32'h300);
         chk("bp_out_rd", out_rd, 3);
      end
      @(posedge CLK); #1; out_ready = 1'b1;
      send(32'h12345537, mk(32'h304, 0, 0,10, 32'h12345000, ALU_ADD, 1,0,1,0,0, 3'd3, 2'd0, 3'd0, 0));
      drain();

      // flush kills a held instruction and blocks the incoming one
      out_ready = 1'b0;
      send(32'h00C280E7, mk(32'h400, 5, 0, 1, 32'hC, ALU_ADD, 1,0,1,0,0, 3'd2, 2'd2, 3'd0, 0));
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFF117; in_pc = 32'h404;
      @(negedge CLK); chk("fl_in_ready", in_ready, 0);
      @(posedge CLK); #1; flush = 1'b0;
      void'(sb.pop_back());
      chk("fl_out_valid", out_valid, 0);
      out_ready = 1'b1;
      send(32'hFFFFF117, mk(32'h404, 0, 0, 2, 32'hFFFFF000, ALU_ADD, 1,0,1,0,0, 3'd4, 2'd0, 3'd0, 0));
      drain();

      // flush while stalled on a load-use hazard
      send(32'h00812283, mk(32'h500, 2, 0, 5, 32'h8, ALU_ADD, 1,0,1,1,0, 3'd1, 2'd0, 3'd0, 0));
      in_valid = 1'b1; in_instr = 32'h00128333; in_pc = 32'h504;
      @(posedge CLK); #1; flush = 1'b1;
      @(negedge CLK); chk("sf_fl_in_ready", in_ready, 0); chk("sf_fl_out_valid", out_valid, 0);
      @(posedge CLK); #1; flush = 1'b0;
      @(negedge CLK); chk("sf_run_in_ready", in_ready, 1); chk("sf_run_out_valid", out_valid, 0);
      sb.push_back(mk(32'h504, 5, 1, 6, 32'h0, ALU_ADD, 0,0,1,0,0, 3'd0, 2'd0, 3'd0, 0));
      @(posedge CLK); #1; in_valid = 1'b0;
      drain();

`ifdef HALT_DETECT_EN
      send(32'h0000007F, mk(32'h600, 0, 0, 0, 32'h0, ALU_ADD, 0,0,0,0,0, 3'd0, 2'd0, 3'd0, 0));
      chk("halt_out_halt", out_halt, 1);
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h604;
      @(negedge CLK); chk("halt_in_ready_0", in_ready, 0);
      @(posedge CLK); #1; flush = 1'b1;
      @(posedge CLK); #1; flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK); chk("halt_in_ready_after_flush", in_ready, 0);
      end
      in_valid = 1'b0;
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
